s27_bist_ctrl: RTL and testbench
================================

S27_BIST_CTRL -- requirements
Module: s27_bist_ctrl

Interface
REQ-001 Parameter NUM_PATTERNS, default 15, number of test patterns applied per run; legal range 1..255.
REQ-002 Parameter FLUSH_CYCLES, default 3, number of cycles pattern 4'b0000 is applied before patterns start; legal range 0..15.
REQ-003 Parameter GOLDEN, default 8'h00, expected signature.
REQ-004 CK  input  1  sole clock; all state SHALL update on the rising edge of CK.
REQ-005 RST  input  1  reset; synchronous and active-high.
REQ-006 START  input  1  run request; sampled only in IDLE.
REQ-007 ABORT  input  1  cancels an active run.
REQ-008 G17  input  1  response from the s27 circuit under test (CUT).
REQ-009 G0, G1, G2, G3  output  1 each  CUT stimulus; {G3,G2,G1,G0} = PAT[3:0].
REQ-010 BUSY  output  1  high in FLUSH and RUN.
REQ-011 DONE  output  1  single-cycle completion pulse.
REQ-012 SIGNATURE  output  8  compacted response.
REQ-013 PASS  output  1  signature-match flag.

Function
REQ-014 States SHALL be IDLE, FLUSH, RUN and DONE, all registered.
REQ-015 IDLE transitions:
- START=1 at an edge -> FLUSH on the next edge (RUN directly if FLUSH_CYCLES=0).
- On that transition: LFSR reseeds to 4'b0001, SIGNATURE clears to 8'h00, PASS clears to 0.
REQ-016 FLUSH SHALL:
- drive PAT=4'b0000;
- last exactly FLUSH_CYCLES cycles, then go to RUN;
- leave SIGNATURE unchanged.
REQ-017 RUN SHALL last exactly NUM_PATTERNS cycles. In each cycle:
- PAT equals the current LFSR value;
- the MISR absorbs G17 at the closing edge;
- the LFSR advances.
REQ-018 LFSR next value SHALL be {L[2:0], L[3]^L[0]}, period 15, starting at 0001 -> 0011 -> 0111 -> 1111 -> 1110. Runs with NUM_PATTERNS > 15 wrap the sequence.
REQ-019 MISR next value SHALL be {S[6:0], S[7]^S[5]^S[4]^S[3]^G17}.
REQ-020 After the final RUN cycle the state SHALL be DONE for exactly one cycle with DONE=1, then return to IDLE.
REQ-021 Outside FLUSH and RUN, PAT SHALL be 4'b0000.
REQ-022 BUSY SHALL be high in FLUSH and RUN and low otherwise; DONE SHALL be high only in DONE.
REQ-023 SIGNATURE and PASS SHALL hold their values until the next accepted START.
REQ-024 START while not in IDLE SHALL be ignored; START held high in IDLE after a DONE SHALL begin a new run.
REQ-025 ABORT=1 in FLUSH or RUN SHALL return to IDLE on the next edge with:
- no DONE pulse;
- PASS=0;
- SIGNATURE frozen at its partial value.
ABORT is ignored in IDLE and DONE.
REQ-026 ABORT and START high in the same IDLE cycle SHALL start a run (ABORT ignored).
REQ-027 Pattern and flush counters SHALL be 8 bits and never wrap within a legal run.

Reset
REQ-028 RST=1 at an edge SHALL force state IDLE, PAT=0, LFSR=4'b0001, SIGNATURE=8'h00, BUSY=0, DONE=0 and PASS=0.
REQ-029 RST SHALL override START and ABORT.
REQ-030 RST asserted mid-run SHALL discard the run with no DONE pulse.

Configuration
REQ-031 When macro S27_BIST_CMP_EN is defined:
- PASS is registered on entry to DONE as (next SIGNATURE == GOLDEN), i.e. including the final absorbed bit;
- PASS is valid from the DONE cycle onward.
REQ-032 When S27_BIST_CMP_EN is not defined:
- PASS is constant 0;
- GOLDEN is unused;
- the port list is unchanged.

Verification
REQ-033 Assert RST for 2 cycles -> all outputs 0, SIGNATURE=8'h00, PAT=0.
REQ-034 Defaults with a START pulse -> 3 cycles of PAT=0000, then PAT=0001,0011,0111,1111,1110,..., 15 RUN cycles, DONE one cycle; BUSY high for exactly 18 cycles.
REQ-035 NUM_PATTERNS=3, FLUSH_CYCLES=2, G17 tied 1, START at edge k:
- BUSY for edges k+1..k+5;
- DONE at k+6;
- SIGNATURE=8'h07;
- with S27_BIST_CMP_EN and GOLDEN=8'h07, PASS=1;
- with GOLDEN=8'h06, PASS=0.
REQ-036 G17 tied 0, defaults -> SIGNATURE=8'h00; PASS=1 with GOLDEN=8'h00 and S27_BIST_CMP_EN defined, 0 without the macro.
REQ-037 ABORT in the 2nd RUN cycle -> IDLE next edge, no DONE, BUSY low, PASS=0; a subsequent START restarts from LFSR=0001, SIGNATURE=8'h00.
REQ-038 RST in the 5th RUN cycle, or START pulsed during RUN -> RST yields the reset values of REQ-028; the START pulse does not alter the run length or DONE timing.

Source files
------------

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 benchmark: LFSR pattern source, flush phase, 8-bit MISR.
// Optional signature compare against GOLDEN is enabled by defining S27_BIST_CMP_EN.
module s27_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 15,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [7:0]  GOLDEN       = 8'h00
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       G17,
  output logic       G0,
  output logic       G1,
  output logic       G2,
  output logic       G3,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] SIGNATURE,
  output logic       PASS
);

`ifdef S27_BIST_CMP_EN
  localparam logic CmpEn = 1'b1;
`else
  // PASS register is never set, so it folds to a constant 0.
  localparam logic CmpEn = 1'b0;
`endif

  localparam logic       HasFlush  = (FLUSH_CYCLES != 0);
  localparam logic [7:0] FlushLast = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] RunLast   = 8'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [7:0] sig_q, sig_d;
  logic       pass_q, pass_d;
  logic [3:0] pat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          lfsr_d  = 4'b0001;
          sig_d   = 8'h00;
          pass_d  = 1'b0;
          cnt_d   = 8'h00;
          state_d = HasFlush ? StFlush : StRun;
        end
      end
      StFlush: begin
        if (ABORT) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == FlushLast) begin
          cnt_d   = 8'h00;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StRun: begin
        if (ABORT) begin
          // Signature freezes at its partial value; the aborting edge absorbs nothing.
          pass_d  = 1'b0;
          state_d = StIdle;
        end else begin
          lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};
          sig_d  = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ G17};
          if (cnt_q == RunLast) begin
            pass_d  = CmpEn & (sig_d == GOLDEN);
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 8'h01;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 8'h00;
      lfsr_q  <= 4'b0001;
      sig_q   <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    pat = (state_q == StRun) ? lfsr_q : 4'b0000;
  end

  assign {G3, G2, G1, G0} = pat;
  assign BUSY      = (state_q == StFlush) || (state_q == StRun);
  assign DONE      = (state_q == StDone);
  assign SIGNATURE = sig_q;
  assign PASS      = pass_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench for s27_bist_ctrl: default instance against a run-offset model,
// plus two small instances (N=3, F=2) driven from a vector table.
module tb_s27_bist_ctrl;

`ifdef S27_BIST_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  localparam int F = 3;
  localparam int N = 15;
  localparam logic [7:0] GOLD = 8'h00;

  logic clk;
  logic rst, start, abort, g17;
  logic g0, g1, g2, g3, busy, done, pass;
  logic [7:0] sig;

  logic s_rst, s_start, s_abort, s_g17;
  logic a0, a1, a2, a3, a_busy, a_done, a_pass;
  logic [7:0] a_sig;
  logic b0, b1, b2, b3, b_busy, b_done, b_pass;
  logic [7:0] b_sig;

  int n_tests = 0;
  int n_fail  = 0;

  s27_bist_ctrl u_dut (
    .CK(clk), .RST(rst), .START(start), .ABORT(abort), .G17(g17),
    .G0(g0), .G1(g1), .G2(g2), .G3(g3), .BUSY(busy), .DONE(done),
    .SIGNATURE(sig), .PASS(pass)
  );

  s27_bist_ctrl #(.NUM_PATTERNS(3), .FLUSH_CYCLES(2), .GOLDEN(8'h07)) u_s7 (
    .CK(clk), .RST(s_rst), .START(s_start), .ABORT(s_abort), .G17(s_g17),
    .G0(a0), .G1(a1), .G2(a2), .G3(a3), .BUSY(a_busy), .DONE(a_done),
    .SIGNATURE(a_sig), .PASS(a_pass)
  );

  s27_bist_ctrl #(.NUM_PATTERNS(3), .FLUSH_CYCLES(2), .GOLDEN(8'h06)) u_s6 (
    .CK(clk), .RST(s_rst), .START(s_start), .ABORT(s_abort), .G17(s_g17),
    .G0(b0), .G1(b1), .G2(b2), .G3(b3), .BUSY(b_busy), .DONE(b_done),
    .SIGNATURE(b_sig), .PASS(b_pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: m_c is the cycle offset since run start (-1 = idle).
  int         m_c;
  logic [7:0] m_sig;
  logic       m_pass;
  logic [3:0] seq [15];

  function automatic logic [7:0] misr(input logic [7:0] s, input logic b);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic rs, input logic g);
    logic [3:0] e_pat;
    start = st;
    abort = ab;
    rst   = rs;
    g17   = g;
    @(posedge clk);
    if (rs) begin
      m_c = -1; m_sig = 8'h00; m_pass = 1'b0;
    end else if (m_c < 0) begin
      if (st) begin
        m_c = 0; m_sig = 8'h00; m_pass = 1'b0;
      end
    end else if (m_c == F + N) begin
      m_c = -1;
    end else if (ab) begin
      m_c = -1; m_pass = 1'b0;
    end else begin
      if (m_c >= F) m_sig = misr(m_sig, g);
      m_c++;
      if (m_c == F + N) m_pass = CMP && (m_sig == GOLD);
    end
    #1;
    e_pat = (m_c >= F && m_c < F + N) ? seq[(m_c - F) % 15] : 4'b0000;
    check("busy", busy, (m_c >= 0 && m_c < F + N));
    check("done", done, (m_c == F + N));
    check("pat", {g3, g2, g1, g0}, e_pat);
    check("signature", sig, m_sig);
    check("pass", pass, m_pass);
  endtask

  typedef struct {
    logic [2:0] g;
    logic [7:0] sig;
    logic       p7;
    logic       p6;
  } vec_t;

  vec_t tbl [6];
  logic [3:0] lit [5];
  int busy_n, done_n, done_at, k;

  initial begin
    tbl[0] = '{3'b111, 8'h07, CMP, 1'b0};
    tbl[1] = '{3'b011, 8'h06, 1'b0, CMP};
    tbl[2] = '{3'b000, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{3'b101, 8'h05, 1'b0, 1'b0};
    tbl[4] = '{3'b100, 8'h01, 1'b0, 1'b0};
    tbl[5] = '{3'b001, 8'h04, 1'b0, 1'b0};
    lit[0] = 4'b0001; lit[1] = 4'b0011; lit[2] = 4'b0111; lit[3] = 4'b1111; lit[4] = 4'b1110;
    seq[0] = 4'b0001;
    for (int i = 1; i < 15; i++)
      seq[i] = {seq[i-1][2:0], seq[i-1][3] ^ seq[i-1][0]};
    m_c = -1; m_sig = 8'h00; m_pass = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_g17 = 1'b0; s_rst = 1'b1;

    // Reset for two cycles.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    s_rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pat", {g3, g2, g1, g0}, 4'b0000);
    check("rst_sig", sig, 8'h00);
    check("rst_pass", pass, 1'b0);
    check("rst_small_out", {a_busy, a_done, a_pass, a3, a2, a1, a0}, 7'b0);
    check("rst_small_sig", a_sig, 8'h00);

    // Table-driven runs on the N=3, F=2 instances.
    for (int r = 0; r < 6; r++) begin
      busy_n = 0; done_at = -1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (k = 0; k < 8; k++) begin
        if (a_busy) busy_n++;
        if (a_done && done_at < 0) done_at = k;
        s_g17 = (k >= 2 && k <= 4) ? tbl[r].g[k-2] : 1'b0;
        @(posedge clk); #1;
      end
      check("tbl_busy_cycles", busy_n, 5);
      check("tbl_done_at", done_at, 5);
      check("tbl_sig_g07", a_sig, tbl[r].sig);
      check("tbl_sig_g06", b_sig, tbl[r].sig);
      check("tbl_pass_g07", a_pass, tbl[r].p7);
      check("tbl_pass_g06", b_pass, tbl[r].p6);
      check("tbl_idle", {a_busy, a_done, b_busy, b_done}, 4'b0);
    end

    // Default run, G17 held 0: pattern order, 18 busy cycles, single DONE.
    busy_n = 0; done_n = 0; done_at = -1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    if (busy) busy_n++;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = i; end
      if (i >= 3 && i < 8) check("lit_pattern", {g3, g2, g1, g0}, lit[i-3]);
    end
    check("def_busy_cycles", busy_n, 18);
    check("def_done_count", done_n, 1);
    check("def_done_at", done_at, 18);
    check("def_sig_zero", sig, 8'h00);
    check("def_pass", pass, CMP);

    // Abort in the second RUN cycle, then restart.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_pass", pass, 1'b0);
    check("abort_sig_partial", sig, 8'h01);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_sig", sig, 8'h00);
    check("restart_busy", busy, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_lfsr", {g3, g2, g1, g0}, 4'b0001);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the fifth RUN cycle.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_out", {busy, done, pass, g3, g2, g1, g0}, 7'b0);
    check("midrst_sig", sig, 8'h00);

    // START pulses during RUN do not move DONE.
    done_at = -1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step((i == 5 || i == 12), 1'b0, 1'b0, 1'b1);
      if (done && done_at < 0) done_at = i;
    end
    check("start_in_run_done_at", done_at, 18);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(63) == 0),
           ($urandom_range(255) == 0), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
